// File: rtl/adder_pkg.sv
// Shared types for the registered adder datapath.
// Build option: define ADDER_SAT_EN for unsigned saturation.
package adder_pkg;

   localparam int ADDER_WIDTH_DEF = 8;

   typedef logic [ADDER_WIDTH_DEF-1:0] adder_word_t;

   typedef struct packed {
      logic carry;
      logic ovf;
      logic zero;
   } adder_flags_t;

   localparam adder_flags_t ADDER_FLAGS_RST = '{
      carry: 1'b0,
      ovf:   1'b0,
      zero:  1'b0
   };

   // Signed overflow: operands agree in sign, result does not.
   function automatic logic adder_ovf(
      input logic a_msb,
      input logic b_msb,
      input logic r_msb
   );
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_core.sv
// Combinational full-sum and flag generation.
// Build option: ADDER_SAT_EN clamps the result to all-ones on carry-out.
module adder_core
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf,
   output logic             zero
);

   logic [WIDTH:0]   full;
   logic [WIDTH-1:0] raw;
   logic             sat;

   assign full  = {1'b0, a} + {1'b0, b};
   assign raw   = full[WIDTH-1:0];
   assign carry = full[WIDTH];

`ifdef ADDER_SAT_EN
   assign sat = full[WIDTH];
`else
   assign sat = 1'b0;
`endif

   always_comb begin
      sum = raw;
      ovf = adder_ovf(a[WIDTH-1], b[WIDTH-1], raw[WIDTH-1]);
      if (sat) begin
         // A clamped result is by definition not a signed overflow.
         sum = '1;
         ovf = 1'b0;
      end
   end

   assign zero = (sum == '0);

endmodule

// File: rtl/adder_unit.sv
// Registered two-operand adder with valid qualifier and status flags.
// Build option: ADDER_SAT_EN selects unsigned saturation.
module adder_unit
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] dout1,
   input  logic [WIDTH-1:0] dout2,
   output logic             out_valid,
   output logic [WIDTH-1:0] add_out,
   output logic             carry,
   output logic             ovf,
   output logic             zero
);

   logic [WIDTH-1:0] sum_c;
   adder_flags_t     flags_c;
   adder_flags_t     flags_q;
   logic [WIDTH-1:0] sum_q;
   logic             valid_q;

   adder_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (dout1),
      .b     (dout2),
      .sum   (sum_c),
      .carry (flags_c.carry),
      .ovf   (flags_c.ovf),
      .zero  (flags_c.zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         flags_q <= ADDER_FLAGS_RST;
      end else begin
         valid_q <= in_valid;
         // Result and flags hold across idle cycles.
         if (in_valid) begin
            sum_q   <= sum_c;
            flags_q <= flags_c;
         end
      end
   end

   assign out_valid = valid_q;
   assign add_out   = sum_q;
   assign carry     = flags_q.carry;
   assign ovf       = flags_q.ovf;
   assign zero      = flags_q.zero;

endmodule

// File: tb/tb_adder_unit.sv
// Directed self-checking bench for adder_unit (WIDTH = 8).
// Define ADDER_SAT_EN here too when building the saturating variant.
module tb_adder_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] dout1;
   logic [7:0] dout2;
   logic       out_valid;
   logic [7:0] add_out;
   logic       carry;
   logic       ovf;
   logic       zero;

   int tests;
   int fails;

   adder_unit #(
      .WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .dout1     (dout1),
      .dout2     (dout2),
      .out_valid (out_valid),
      .add_out   (add_out),
      .carry     (carry),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(
      input logic       v,
      input logic [7:0] a,
      input logic [7:0] b
   );
      @(negedge clk);
      in_valid = v;
      dout1    = a;
      dout2    = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      dout1    = 8'h00;
      dout2    = 8'h00;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({out_valid, add_out, carry, ovf, zero} !== 12'h000) begin
         fails++;
         $display("FAIL reset_init: got v=%b s=%h c=%b o=%b z=%b want all 0",
                  out_valid, add_out, carry, ovf, zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'h81, 8'h83);
      step();
      tests++;
      if (out_valid !== 1'b1 || add_out === 8'h00) begin
         fails++;
         $display("FAIL reset_pre: got v=%b s=%h want v=1 nonzero sum",
                  out_valid, add_out);
      end
      // Async assert between edges while in_valid stays high.
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({out_valid, add_out, carry, ovf, zero} !== 12'h000) begin
         fails++;
         $display("FAIL reset_mid: got v=%b s=%h c=%b o=%b z=%b want all 0",
                  out_valid, add_out, carry, ovf, zero);
      end
      step();
      tests++;
      if ({out_valid, add_out, carry, ovf, zero} !== 12'h000) begin
         fails++;
         $display("FAIL reset_held: got v=%b s=%h want all 0",
                  out_valid, add_out);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         tests++;
         if ({out_valid, add_out, carry, ovf, zero} !== 12'h000) begin
            fails++;
            $display("FAIL reset_release%0d: got v=%b s=%h want all 0",
                     i, out_valid, add_out);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a [3];
      logic [7:0] b [3];
      logic [7:0] s [3];
      a = '{8'h08, 8'h0B, 8'h1B};
      b = '{8'h03, 8'h1C, 8'h53};
      s = '{8'h0B, 8'h27, 8'h6E};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, a[i], b[i]);
         step();
         tests++;
         if ({out_valid, add_out, carry, ovf, zero} !==
             {1'b1, s[i], 3'b000}) begin
            fails++;
            $display("FAIL basic%0d: got v=%b s=%h c=%b o=%b z=%b want v=1 s=%h c=0 o=0 z=0",
                     i, out_valid, add_out, carry, ovf, zero, s[i]);
         end
      end
      drive(1'b0, 8'h00, 8'h00);
      step();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_idle: got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_flags();
      logic [7:0] a [5];
      logic [7:0] b [5];
      logic [7:0] s [5];
      logic [2:0] f [5];
      a = '{8'h81, 8'hDB, 8'h5B, 8'h00, 8'hFF};
      b = '{8'h83, 8'hD3, 8'hE3, 8'h00, 8'h01};
`ifdef ADDER_SAT_EN
      s = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
      f = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
`else
      s = '{8'h04, 8'hAE, 8'h3E, 8'h00, 8'h00};
      f = '{3'b110, 3'b100, 3'b100, 3'b001, 3'b101};
`endif
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, a[i], b[i]);
         step();
         tests++;
         if ({out_valid, add_out, carry, ovf, zero} !==
             {1'b1, s[i], f[i]}) begin
            fails++;
            $display("FAIL flags%0d: got v=%b s=%h coz=%b%b%b want v=1 s=%h coz=%b",
                     i, out_valid, add_out, carry, ovf, zero, s[i], f[i]);
         end
      end
   endtask

   task automatic test_hold();
      drive(1'b1, 8'h08, 8'h03);
      step();
      tests++;
      if (out_valid !== 1'b1 || add_out !== 8'h0B) begin
         fails++;
         $display("FAIL hold_load: got v=%b s=%h want v=1 s=0b",
                  out_valid, add_out);
      end
      // Mid-cycle operand change must not reach the outputs.
      dout1 = 8'hFF;
      dout2 = 8'hFF;
      #1;
      tests++;
      if (add_out !== 8'h0B || carry !== 1'b0) begin
         fails++;
         $display("FAIL hold_comb: got s=%h c=%b want s=0b c=0",
                  add_out, carry);
      end
      drive(1'b0, 8'hFF, 8'h01);
      for (int i = 0; i < 2; i++) begin
         step();
         tests++;
         if ({out_valid, add_out, carry, ovf, zero} !==
             {1'b0, 8'h0B, 3'b000}) begin
            fails++;
            $display("FAIL hold%0d: got v=%b s=%h coz=%b%b%b want v=0 s=0b coz=000",
                     i, out_valid, add_out, carry, ovf, zero);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_back_to_back();
      test_flags();
      test_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adder_unit.md
Name: adder_unit

Overview:
- Registered two-operand unsigned adder for the memory-to-memory transfer datapath.
- Sums two words read from source memories (dout1, dout2) and presents the result (add_out) for write-back to the destination memory.
- One clock, single-cycle latency, valid qualifier, status flags (carry, signed overflow, zero).
- Wrap-around (modulo 2^WIDTH) arithmetic by default; saturation selectable at compile time.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on dout1/dout2 are valid this cycle
- dout1  input  WIDTH  operand A (memory 1 read data)
- dout2  input  WIDTH  operand B (memory 2 read data)
- out_valid  output  1  add_out and flags hold a new result
- add_out  output  WIDTH  registered sum
- carry  output  1  unsigned carry-out of the sum
- ovf  output  1  two's-complement signed overflow
- zero  output  1  add_out == 0

Behaviour:
- Reset (rst_n low, asynchronous): add_out = 0, carry = 0, ovf = 0, zero = 0, out_valid = 0. These values hold while rst_n is low. Reset release is synchronous to clk; the first capture occurs on the first rising edge after rst_n is high.
- Arithmetic: full sum = dout1 + dout2, computed at WIDTH+1 bits.
  - carry = bit WIDTH of the full sum.
  - add_out = low WIDTH bits of the full sum.
  - ovf = 1 when the operand MSBs are equal and the result MSB differs from them.
  - zero = (add_out == 0), evaluated on the value actually registered.
- Latency: exactly 1 cycle. Operands sampled on rising edge N appear on the outputs after edge N.
- in_valid = 1 at an edge: result and flags registered, out_valid = 1 for the following cycle.
- in_valid = 0 at an edge: add_out and flags hold their previous values, out_valid = 0.
- No backpressure. The block accepts a new operand pair every cycle (throughput 1/cycle).
- Back-to-back valid inputs produce back-to-back valid outputs with no bubble.
- Wrap-around: 0xFF + 0x01 → add_out 0x00, carry 1, zero 1, ovf 0.
- Reset mid-operation: an in-flight result is discarded and out_valid drops immediately.
- Operand changes between edges have no effect on the outputs; outputs are fully registered and no combinational path runs from input to output.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined: unsigned saturation. When the full sum exceeds 2^WIDTH−1, add_out = all-ones (0xFF for WIDTH=8). carry still reports the raw carry-out. ovf and zero are computed on the saturated value, with ovf = 0 whenever saturation occurs.
- Undefined: plain modulo-2^WIDTH wrap-around as above.

Decomposition:
- Shared package adder_pkg:
  - localparam default width 8.
  - typedef for a WIDTH-bit data word.
  - packed struct adder_flags_t {carry, ovf, zero}.
- One natural sub-module, adder_core: purely combinational full-sum and flag generation (including the saturation path).
- adder_unit instantiates adder_core and adds the output registers and valid pipeline.

Test Plan:
- Reset: assert rst_n = 0 mid-run with in_valid = 1 → all outputs 0 immediately; after release with in_valid = 0, outputs stay 0.
- Basic sums, one pair per cycle, in_valid = 1:
  - 0x08 + 0x03 → 0x0B
  - 0x0B + 0x1C → 0x27
  - 0x1B + 0x53 → 0x6E
  - Each with carry 0, ovf 0, zero 0, and out_valid high the cycle after each input.
- Carry / overflow cases:
  - 0x81 + 0x83 → 0x04, carry 1, ovf 1.
  - 0xDB + 0xD3 → 0xAE, carry 1, ovf 0.
  - 0x5B + 0xE3 → 0x3E, carry 1, ovf 0.
- Zero / wrap: 0x00 + 0x00 → 0x00, zero 1; 0xFF + 0x01 → 0x00, carry 1, zero 1.
- Hold: pulse in_valid for one cycle with 0x08 + 0x03, then change operands with in_valid = 0 → add_out stays 0x0B, out_valid 0.
- With ADDER_SAT_EN defined: 0x81 + 0x83 → 0xFF, carry 1, ovf 0; 0x08 + 0x03 → 0x0B unchanged.
